// File: rtl/universal_counter.sv
// universal_counter: mod-MODULUS LOAD/INC/DEC/HOLD counter with active-low carry chain, wrap pulse and sticky ovf.
// Optional compare/match register is enabled by defining UNIVERSAL_COUNTER_MATCH_EN.
module universal_counter #(
    parameter int WIDTH = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d,
    input  logic             nCryIn,
    input  logic             clr,
    input  logic             ovfClr,
    input  logic [WIDTH-1:0] cmpVal,
    input  logic             cmpLoad,
    output logic [WIDTH-1:0] q,
    output logic             nCryOut,
    output logic             wrap,
    output logic             ovf,
    output logic             match
);
    localparam logic [1:0] LOAD = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] DEC = 2'b10;
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 64'd1);
    logic             carryIn;
    logic             tc;
    logic             wrapEvt;
    logic [WIDTH:0]   incSum;
    logic [WIDTH:0]   decSum;
    logic [WIDTH-1:0] qNext;
    // One extra bit lets q+1 reach 2**WIDTH and exposes the borrow of 0-1.
    always_comb begin
        incSum = {1'b0, q} + 1'b1;
        decSum = {1'b0, q} - 1'b1;
        carryIn = !nCryIn;
        tc = (sel == INC) ? (incSum >= MOD_EXT) : (sel == DEC) ? decSum[WIDTH] : 1'b0;
        wrapEvt = carryIn && tc && !clr;
        qNext = clr ? '0 :
                (sel == LOAD) ? d :
                !carryIn ? q :
                (sel == INC) ? (tc ? '0 : incSum[WIDTH-1:0]) :
                (sel == DEC) ? (tc ? LAST[WIDTH-1:0] : decSum[WIDTH-1:0]) : q;
    end
    assign nCryOut = !(carryIn && tc);
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            q <= RESET_VAL;
            wrap <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q <= qNext;
            wrap <= wrapEvt;
            ovf <= wrapEvt || (ovf && !ovfClr);
        end
    end
`ifdef UNIVERSAL_COUNTER_MATCH_EN
    logic [WIDTH-1:0] cmpReg;
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) cmpReg <= '1;
        else if (cmpLoad) cmpReg <= cmpVal;
    end
    assign match = (q == cmpReg);
`else
    logic unusedCmp;
    assign unusedCmp = ^{cmpVal, cmpLoad};
    assign match = 1'b0;
`endif
endmodule

// File: tb/tb_universal_counter.sv
// tb_universal_counter: directed checks of universal_counter (8-bit, mod-10 and a two-stage cascade).
module tb_universal_counter;
`ifdef UNIVERSAL_COUNTER_MATCH_EN
    localparam logic MEN = 1'b1;
`else
    localparam logic MEN = 1'b0;
`endif
    localparam logic [1:0] LOAD = 2'b00, INC = 2'b01, DEC = 2'b10, HOLD = 2'b11;
    logic clk = 1'b0, nReset;
    int nVec = 0, nErr = 0;
    always #5 clk = ~clk;

    logic [1:0] aSel; logic [7:0] aD, aCmpVal, aQ; logic aNCry, aClr, aOvfClr, aCmpLoad, aNco, aWrap, aOvf, aMatch;
    logic [1:0] bSel; logic [3:0] bD, bQ; logic bNCry, bClr, bOvfClr, bNco, bWrap, bOvf, bMatch;
    logic [1:0] cSel; logic [7:0] cD; logic cNCry, cClr;
    logic [3:0] loQ, hiQ; logic loNco, hiNco, loWrap, hiWrap, loOvf, hiOvf, loMatch, hiMatch;

    universal_counter #(.WIDTH(8), .MODULUS(256), .RESET_VAL(5)) dutA (
        .clk(clk), .nReset(nReset), .sel(aSel), .d(aD), .nCryIn(aNCry), .clr(aClr), .ovfClr(aOvfClr),
        .cmpVal(aCmpVal), .cmpLoad(aCmpLoad), .q(aQ), .nCryOut(aNco), .wrap(aWrap), .ovf(aOvf), .match(aMatch));
    universal_counter #(.WIDTH(4), .MODULUS(10)) dutB (
        .clk(clk), .nReset(nReset), .sel(bSel), .d(bD), .nCryIn(bNCry), .clr(bClr), .ovfClr(bOvfClr),
        .cmpVal(4'h0), .cmpLoad(1'b0), .q(bQ), .nCryOut(bNco), .wrap(bWrap), .ovf(bOvf), .match(bMatch));
    universal_counter #(.WIDTH(4), .MODULUS(16)) dutLo (
        .clk(clk), .nReset(nReset), .sel(cSel), .d(cD[3:0]), .nCryIn(cNCry), .clr(cClr), .ovfClr(1'b0),
        .cmpVal(4'h0), .cmpLoad(1'b0), .q(loQ), .nCryOut(loNco), .wrap(loWrap), .ovf(loOvf), .match(loMatch));
    universal_counter #(.WIDTH(4), .MODULUS(16)) dutHi (
        .clk(clk), .nReset(nReset), .sel(cSel), .d(cD[7:4]), .nCryIn(loNco), .clr(cClr), .ovfClr(1'b0),
        .cmpVal(4'h0), .cmpLoad(1'b0), .q(hiQ), .nCryOut(hiNco), .wrap(hiWrap), .ovf(hiOvf), .match(hiMatch));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        aSel = INC; aNCry = 1'b0;
        step; step;
        nVec++; if (aQ !== 8'h07) begin nErr++; $display("FAIL reset_precount: q=%0h expected 7", aQ); end
        #3 nReset = 1'b0;
        #1;
        nVec++; if (aQ !== 8'h05) begin nErr++; $display("FAIL reset_q: q=%0h expected 5", aQ); end
        nVec++; if ({aWrap, aOvf} !== 2'b00) begin nErr++; $display("FAIL reset_flags: wrap/ovf=%b expected 00", {aWrap, aOvf}); end
        nVec++; if (aNco !== 1'b1) begin nErr++; $display("FAIL reset_nco: nCryOut=%b expected 1", aNco); end
        #2 nReset = 1'b1;
        aSel = LOAD; aD = 8'h3C;
        step;
        nVec++; if (aQ !== 8'h3C) begin nErr++; $display("FAIL load_3c: q=%0h expected 3c", aQ); end
        aSel = HOLD; aNCry = 1'b1;
    endtask

    task automatic test_inc_wrap;
        bSel = LOAD; bD = 4'd8; bNCry = 1'b1;
        step;
        nVec++; if (bQ !== 4'd8) begin nErr++; $display("FAIL inc_load8: q=%0d expected 8", bQ); end
        bSel = INC; bNCry = 1'b0;
        #1;
        nVec++; if (bNco !== 1'b1) begin nErr++; $display("FAIL inc_nco_at8: nCryOut=%b expected 1", bNco); end
        step;
        nVec++; if ({bQ, bNco, bWrap} !== {4'd9, 1'b0, 1'b0}) begin nErr++; $display("FAIL inc_q9: q/nco/wrap=%0d/%b/%b expected 9/0/0", bQ, bNco, bWrap); end
        step;
        nVec++; if ({bQ, bNco, bWrap, bOvf} !== {4'd0, 1'b1, 1'b1, 1'b1}) begin nErr++; $display("FAIL inc_wrap0: q/nco/wrap/ovf=%0d/%b/%b/%b expected 0/1/1/1", bQ, bNco, bWrap, bOvf); end
        step;
        nVec++; if ({bQ, bWrap, bOvf} !== {4'd1, 1'b0, 1'b1}) begin nErr++; $display("FAIL inc_q1: q/wrap/ovf=%0d/%b/%b expected 1/0/1", bQ, bWrap, bOvf); end
        nVec++; if (bMatch !== 1'b0) begin nErr++; $display("FAIL inc_match_b: match=%b expected 0", bMatch); end
    endtask

    task automatic test_dec_enable;
        bSel = LOAD; bD = 4'd1;
        step;
        bSel = DEC; bNCry = 1'b0;
        step;
        nVec++; if ({bQ, bNco} !== {4'd0, 1'b0}) begin nErr++; $display("FAIL dec_q0: q/nco=%0d/%b expected 0/0", bQ, bNco); end
        step;
        nVec++; if ({bQ, bNco, bWrap} !== {4'd9, 1'b1, 1'b1}) begin nErr++; $display("FAIL dec_wrap9: q/nco/wrap=%0d/%b/%b expected 9/1/1", bQ, bNco, bWrap); end
        bNCry = 1'b1;
        step;
        nVec++; if ({bQ, bWrap} !== {4'd9, 1'b0}) begin nErr++; $display("FAIL dec_hold: q/wrap=%0d/%b expected 9/0", bQ, bWrap); end
        bSel = LOAD; bD = 4'd0;
        step;
        bSel = DEC;
        #1;
        nVec++; if (bNco !== 1'b1) begin nErr++; $display("FAIL dec_nco_disabled: nCryOut=%b expected 1", bNco); end
        step;
        nVec++; if (bQ !== 4'd0) begin nErr++; $display("FAIL dec_hold0: q=%0d expected 0", bQ); end
    endtask

    task automatic test_priority;
        bClr = 1'b1; bSel = LOAD; bD = 4'd7;
        step;
        nVec++; if ({bQ, bOvf} !== {4'd0, 1'b1}) begin nErr++; $display("FAIL clr_over_load: q/ovf=%0d/%b expected 0/1", bQ, bOvf); end
        bClr = 1'b0; bD = 4'd9;
        step;
        bSel = INC; bNCry = 1'b0; bClr = 1'b1;
        #1;
        nVec++; if (bNco !== 1'b0) begin nErr++; $display("FAIL nco_ignores_clr: nCryOut=%b expected 0", bNco); end
        step;
        nVec++; if ({bQ, bWrap, bOvf} !== {4'd0, 1'b0, 1'b1}) begin nErr++; $display("FAIL clr_no_wrap: q/wrap/ovf=%0d/%b/%b expected 0/0/1", bQ, bWrap, bOvf); end
        bClr = 1'b0; bSel = LOAD; bD = 4'd9; bOvfClr = 1'b1;
        step;
        nVec++; if ({bQ, bOvf} !== {4'd9, 1'b0}) begin nErr++; $display("FAIL ovfclr: q/ovf=%0d/%b expected 9/0", bQ, bOvf); end
        bSel = INC;
        step;
        nVec++; if ({bQ, bWrap, bOvf} !== {4'd0, 1'b1, 1'b1}) begin nErr++; $display("FAIL ovf_set_wins: q/wrap/ovf=%0d/%b/%b expected 0/1/1", bQ, bWrap, bOvf); end
        bSel = HOLD;
        step;
        nVec++; if ({bQ, bWrap, bOvf} !== {4'd0, 1'b0, 1'b0}) begin nErr++; $display("FAIL ovf_cleared: q/wrap/ovf=%0d/%b/%b expected 0/0/0", bQ, bWrap, bOvf); end
        bOvfClr = 1'b0; bSel = LOAD; bD = 4'd12;
        step;
        nVec++; if (bQ !== 4'd12) begin nErr++; $display("FAIL load_oob: q=%0d expected 12", bQ); end
        bSel = INC;
        #1;
        nVec++; if (bNco !== 1'b0) begin nErr++; $display("FAIL oob_tc: nCryOut=%b expected 0", bNco); end
        step;
        nVec++; if ({bQ, bWrap} !== {4'd0, 1'b1}) begin nErr++; $display("FAIL oob_wrap: q/wrap=%0d/%b expected 0/1", bQ, bWrap); end
        bSel = HOLD; bNCry = 1'b1;
    endtask

    task automatic test_cascade;
        cSel = LOAD; cD = 8'h0F; cNCry = 1'b0;
        step;
        nVec++; if ({loMatch, hiMatch} !== {MEN, 1'b0}) begin nErr++; $display("FAIL casc_match0f: match lo/hi=%b expected %b", {loMatch, hiMatch}, {MEN, 1'b0}); end
        cSel = INC;
        step;
        nVec++; if ({hiQ, loQ, hiNco} !== {8'h10, 1'b1}) begin nErr++; $display("FAIL casc_10: q/nco=%0h/%b expected 10/1", {hiQ, loQ}, hiNco); end
        cSel = LOAD; cD = 8'hFF;
        step;
        cSel = INC;
        #1;
        nVec++; if ({loNco, hiNco, loMatch, hiMatch} !== {1'b0, 1'b0, MEN, MEN}) begin nErr++; $display("FAIL casc_ff_nco: nco lo/hi match lo/hi=%b expected %b", {loNco, hiNco, loMatch, hiMatch}, {2'b00, MEN, MEN}); end
        step;
        nVec++; if ({hiQ, loQ, hiWrap, hiOvf} !== {8'h00, 1'b1, 1'b1}) begin nErr++; $display("FAIL casc_00: q/wrap/ovf=%0h/%b/%b expected 00/1/1", {hiQ, loQ}, hiWrap, hiOvf); end
        cSel = DEC;
        #1;
        nVec++; if (hiNco !== 1'b0) begin nErr++; $display("FAIL casc_dec_nco: nCryOut=%b expected 0", hiNco); end
        step;
        nVec++; if ({hiQ, loQ, loWrap, loOvf} !== {8'hFF, 1'b1, 1'b1}) begin nErr++; $display("FAIL casc_dec_ff: q/wrap/ovf=%0h/%b/%b expected ff/1/1", {hiQ, loQ}, loWrap, loOvf); end
        cSel = HOLD; cNCry = 1'b1;
    endtask

    task automatic test_match;
        aSel = LOAD; aD = 8'hFF;
        step;
        nVec++; if (aMatch !== MEN) begin nErr++; $display("FAIL match_reset_cmp: match=%b expected %b", aMatch, MEN); end
        aD = 8'h04; aCmpVal = 8'h06; aCmpLoad = 1'b1;
        step;
        aCmpLoad = 1'b0; aSel = INC; aNCry = 1'b0;
        #1;
        nVec++; if ({aQ, aMatch} !== {8'h04, 1'b0}) begin nErr++; $display("FAIL match_q4: q/match=%0h/%b expected 4/0", aQ, aMatch); end
        step;
        nVec++; if ({aQ, aMatch} !== {8'h05, 1'b0}) begin nErr++; $display("FAIL match_q5: q/match=%0h/%b expected 5/0", aQ, aMatch); end
        step;
        nVec++; if ({aQ, aMatch} !== {8'h06, MEN}) begin nErr++; $display("FAIL match_q6: q/match=%0h/%b expected 6/%b", aQ, aMatch, MEN); end
        step;
        nVec++; if ({aQ, aMatch} !== {8'h07, 1'b0}) begin nErr++; $display("FAIL match_q7: q/match=%0h/%b expected 7/0", aQ, aMatch); end
        aSel = HOLD; aNCry = 1'b1;
    endtask

    initial begin
        nReset = 1'b0;
        aSel = HOLD; aD = '0; aNCry = 1'b1; aClr = 1'b0; aOvfClr = 1'b0; aCmpVal = '0; aCmpLoad = 1'b0;
        bSel = HOLD; bD = '0; bNCry = 1'b1; bClr = 1'b0; bOvfClr = 1'b0;
        cSel = HOLD; cD = '0; cNCry = 1'b1; cClr = 1'b0;
        #12 nReset = 1'b1;
        test_reset;
        test_inc_wrap;
        test_dec_enable;
        test_priority;
        test_cascade;
        test_match;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
